// File: rtl/i2c_bus_scheduler_if.sv
// Purpose: requester-side and i2c_master-side signals of the bus scheduler.
// Latency: none (signal bundle only).
// Backpressure: requests are level-held until their response pulse.
interface i2c_bus_scheduler_if;
  logic [3:0]  req;
  logic [27:0] req_dev_addr;
  logic [31:0] req_reg_addr;
  logic [3:0]  rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic [1:0]  grant_id;
  logic        bus_active;
  logic        m_start;
  logic [6:0]  m_dev_addr;
  logic [7:0]  m_reg_addr;
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_read_data;

  // Scheduler view
  modport master (
    input  req, req_dev_addr, req_reg_addr, m_busy, m_done, m_read_data,
    output rsp_valid, rsp_err, rsp_data, grant_id, bus_active,
           m_start, m_dev_addr, m_reg_addr
  );

  // Requester / i2c_master view
  modport slave (
    output req, req_dev_addr, req_reg_addr, m_busy, m_done, m_read_data,
    input  rsp_valid, rsp_err, rsp_data, grant_id, bus_active,
           m_start, m_dev_addr, m_reg_addr
  );
endinterface

// File: rtl/i2c_bus_scheduler.sv
// Purpose: round-robin share of one i2c_master among four read requesters, with bus-idle gap and watchdog.
// Latency: request sampled in IDLE -> m_start next cycle; m_done -> response pulse next cycle.
// Backpressure: one transaction in flight; requests wait (level-held) until granted, none sampled during GAP.
module i2c_bus_scheduler #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int GAP_CYCLES     = 64
) (
  input logic clk,
  input logic rst,
  i2c_bus_scheduler_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  // A zero gap still spends one cycle in GAP before returning to IDLE.
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    grant_q, grant_d;
  logic [TW-1:0] to_q, to_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          m_start_q, m_start_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [3:0]    rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          active_q, active_d;

  logic       pick_vld;
  logic [1:0] pick, cand;
  logic [6:0] sel_dev;
  logic [7:0] sel_reg;

  // Round-robin pick: first pending requester after the last one granted
  always_comb begin
    pick_vld = 1'b0;
    pick     = last_q;
    cand     = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Address mux for the picked requester
  always_comb begin
    sel_dev = '0;
    sel_reg = '0;
    for (int i = 0; i < 4; i++) begin
      if (pick == 2'(i)) begin
        sel_dev = bus.req_dev_addr[7*i +: 7];
        sel_reg = bus.req_reg_addr[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    to_d        = to_q;
    gap_d       = gap_q;
    m_start_d   = 1'b0;
    dev_d       = dev_q;
    reg_d       = reg_q;
    rsp_valid_d = '0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    active_d    = active_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d   = pick;
          last_d    = pick;
          dev_d     = sel_dev;
          reg_d     = sel_reg;
          m_start_d = 1'b1;
          active_d  = 1'b1;
          to_d      = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        to_d = to_q + TW'(1);
        // A completion on the watchdog's last cycle still counts as success.
        if (bus.m_done) begin
          rsp_data_d  = bus.m_read_data;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 4'b0001 << grant_q;
          active_d    = 1'b0;
          gap_d       = '0;
          state_d     = GAP;
        end else if (to_q == TO_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 4'b0001 << grant_q;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // Wait out the hung master; its late m_done is already answered.
        if (!bus.m_busy) begin
          active_d = 1'b0;
          gap_d    = '0;
          state_d  = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 2'd3;
      grant_q     <= '0;
      to_q        <= '0;
      gap_q       <= '0;
      m_start_q   <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      to_q        <= to_d;
      gap_q       <= gap_d;
      m_start_q   <= m_start_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      active_q    <= active_d;
    end
  end

  assign bus.m_start    = m_start_q;
  assign bus.m_dev_addr = dev_q;
  assign bus.m_reg_addr = reg_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.grant_id   = grant_q;
  assign bus.bus_active = active_q;

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Purpose: self-checking bench for i2c_bus_scheduler with an i2c_master model and round-robin reference.
// Latency: expectations derived from the model's done latency, watchdog length and gap length.
// Backpressure: requests held until their response, then dropped by the bench.
module tb_i2c_bus_scheduler;
  localparam int T = 100;
  localparam int G = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  i2c_bus_scheduler_if bus();

  i2c_bus_scheduler #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, n_start = 0, n_rsp = 0, st_cyc = 0, rsp_cyc = 0, overlap = 0;

  // i2c_master model controls
  int          mdl_lat = 10;
  logic [15:0] mdl_data = 16'h0;
  bit          mdl_hang = 1'b0;
  int          mdl_busy_len = 300;
  int          mdl_late = 150;

  // Reference state
  logic [6:0] dev_a [4];
  logic [7:0] reg_a [4];
  int         last_m = 3;
  int         cur_id = 0;
  logic [6:0] cur_dev = '0;

  // Event monitor: counts start pulses and responses, flags multi-bit responses
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.m_start) begin n_start++; st_cyc = cyc; end
      if (bus.rsp_valid != 4'b0) begin
        n_rsp++;
        rsp_cyc = cyc;
        if (!$onehot(bus.rsp_valid)) overlap++;
      end
    end
  end

  // i2c_master model: done 'mdl_lat' cycles after start, or hang with a late stale done
  initial begin
    int cnt;
    bit act;
    cnt = 0; act = 1'b0;
    bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_read_data = '0;
    forever begin
      @(negedge clk);
      bus.m_done = 1'b0;
      if (!rst) begin
        act = 1'b0; bus.m_busy = 1'b0;
      end else if (bus.m_start) begin
        act = 1'b1; cnt = 0; bus.m_busy = 1'b1;
      end else if (act) begin
        cnt++;
        if (mdl_hang) begin
          if (cnt == mdl_late) bus.m_done = 1'b1;
          if (cnt == mdl_busy_len) begin bus.m_busy = 1'b0; act = 1'b0; end
        end else if (cnt == mdl_lat) begin
          bus.m_done = 1'b1; bus.m_read_data = mdl_data; bus.m_busy = 1'b0; act = 1'b0;
        end
      end
    end
  end

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_addrs();
    for (int i = 0; i < 4; i++) begin
      bus.req_dev_addr[7*i +: 7] = dev_a[i];
      bus.req_reg_addr[8*i +: 8] = reg_a[i];
    end
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < 4; i++) begin
      dev_a[i] = 7'($urandom);
      reg_a[i] = 8'($urandom);
    end
    drive_addrs();
  endtask

  task automatic set_mdl();
    mdl_lat  = $urandom_range(1, 60);
    mdl_data = 16'($urandom);
  endtask

  // Wait for a grant and check it against the round-robin rule
  task automatic serve_start(input string tag, input bit b2b);
    int n0, id;
    bit ok;
    n0 = n_start; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (n_start != n0) begin ok = 1'b1; break; end
      tick();
    end
    chk({tag, " start seen"}, 32'(ok), 32'd1);
    id = rr_pick(bus.req, last_m);
    chk({tag, " grant"}, 32'(bus.grant_id), 32'(id));
    chk({tag, " dev"}, 32'(bus.m_dev_addr), 32'(dev_a[id & 3]));
    chk({tag, " reg"}, 32'(bus.m_reg_addr), 32'(reg_a[id & 3]));
    chk({tag, " active"}, 32'(bus.bus_active), 32'd1);
    // G idle cycles lie strictly between the previous response and this start
    if (b2b) chk({tag, " gap"}, 32'(st_cyc - rsp_cyc), 32'(G + 1));
    last_m  = id & 3;
    cur_id  = id & 3;
    cur_dev = dev_a[id & 3];
    rand_addrs();
  endtask

  // Wait for the successful response of the current grant
  task automatic serve_end(input string tag, input bit drop);
    int n0;
    bit ok;
    n0 = n_rsp; ok = 1'b0;
    tick();
    chk({tag, " start pulse"}, 32'(bus.m_start), 32'd0);
    for (int i = 0; i < T + 50; i++) begin
      if (n_rsp != n0) begin ok = 1'b1; break; end
      tick();
    end
    chk({tag, " rsp seen"}, 32'(ok), 32'd1);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(4'b0001 << cur_id));
    chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(mdl_data));
    chk({tag, " rsp latency"}, 32'(rsp_cyc - st_cyc), 32'(mdl_lat + 1));
    chk({tag, " active in gap"}, 32'(bus.bus_active), 32'd0);
    chk({tag, " addr held"}, 32'(bus.m_dev_addr), 32'(cur_dev));
    if (drop) bus.req[cur_id] = 1'b0;
  endtask

  initial begin
    int tq, t0, t_low, n0, ns;
    bit ok;
    bus.req = '0; bus.req_dev_addr = '0; bus.req_reg_addr = '0;
    for (int i = 0; i < 4; i++) begin dev_a[i] = '0; reg_a[i] = '0; end
    rst = 1'b0;
    repeat (3) tick();
    chk("reset m_start", 32'(bus.m_start), 32'd0);
    chk("reset outputs", {bus.m_dev_addr, bus.m_reg_addr, bus.rsp_valid, bus.rsp_err,
                          bus.grant_id, bus.bus_active}, 32'd0);
    chk("reset rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b1;
    tick();

    // Single request with fixed addresses and data
    dev_a[0] = 7'h44; reg_a[0] = 8'h00; drive_addrs();
    mdl_lat = 50; mdl_data = 16'h1A2B;
    tq = cyc;
    bus.req = 4'b0001;
    serve_start("single", 1'b0);
    chk("single req->start", 32'(st_cyc - tq), 32'd1);
    serve_end("single", 1'b1);
    repeat (G + 5) tick();

    // Fairness from reset with all requesters held
    rst = 1'b0; tick(); rst = 1'b1; last_m = 3; tick();
    bus.req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      set_mdl();
      serve_start($sformatf("fair%0d", k), k > 0);
      chk($sformatf("fair%0d order", k), 32'(bus.grant_id), 32'(k % 4));
      serve_end($sformatf("fair%0d", k), 1'b0);
    end
    bus.req = '0;
    repeat (G + 5) tick();

    // Rotation: last grant was 1, so 2 precedes 0
    bus.req = 4'b0101;
    set_mdl(); serve_start("rot0", 1'b0);
    chk("rot first", 32'(bus.grant_id), 32'd2);
    serve_end("rot0", 1'b1);
    set_mdl(); serve_start("rot1", 1'b1);
    chk("rot second", 32'(bus.grant_id), 32'd0);
    serve_end("rot1", 1'b1);

    // Random request sets, each requester dropped once served
    for (int r = 0; r < 5; r++) begin
      repeat (G + 5) tick();
      bus.req = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4 && bus.req != 4'b0; j++) begin
        set_mdl();
        serve_start($sformatf("rnd%0d_%0d", r, j), j > 0);
        serve_end($sformatf("rnd%0d_%0d", r, j), 1'b1);
      end
      chk("rnd drained", 32'(bus.req), 32'd0);
    end
    repeat (G + 5) tick();

    // Withdrawal: requester 3 appears and leaves mid-transaction; owner drops after grant
    mdl_lat = 40; mdl_data = 16'h5A5A;
    bus.req = 4'b0001;
    serve_start("wd", 1'b0);
    bus.req = 4'b1000;
    repeat (10) tick();
    bus.req = 4'b0000;
    serve_end("wd", 1'b0);
    ns = n_start; n0 = n_rsp;
    repeat (G + 20) tick();
    chk("wd no grant", 32'(n_start), 32'(ns));
    chk("wd no rsp", 32'(n_rsp), 32'(n0));

    // Done on the watchdog's final cycle is a success
    mdl_lat = T - 1; mdl_data = 16'hC0DE;
    bus.req = 4'b1000;
    serve_start("bnd", 1'b0);
    serve_end("bnd", 1'b1);
    repeat (G + 5) tick();

    // Hung transaction: error response, drain, stale done ignored
    mdl_hang = 1'b1; mdl_busy_len = 300; mdl_late = 150;
    bus.req = 4'b0100;
    serve_start("to", 1'b0);
    t0 = st_cyc; n0 = n_rsp; ok = 1'b0;
    for (int i = 0; i < T + 20; i++) begin
      if (n_rsp != n0) begin ok = 1'b1; break; end
      tick();
    end
    chk("to rsp seen", 32'(ok), 32'd1);
    chk("to latency", 32'(rsp_cyc - t0), 32'(T));
    chk("to rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("to rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("to rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("to active drain", 32'(bus.bus_active), 32'd1);
    n0 = n_rsp; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.m_busy) begin ok = 1'b1; break; end
      tick();
    end
    chk("to busy fell", 32'(ok), 32'd1);
    t_low = cyc;
    mdl_hang = 1'b0; mdl_lat = 20; mdl_data = 16'hBEEF;
    serve_start("after_to", 1'b0);
    chk("after_to spacing", 32'(st_cyc - t_low), 32'(G + 2));
    chk("late done ignored", 32'(n_rsp), 32'(n0));
    serve_end("after_to", 1'b0);
    repeat (G + 5) tick();

    // Reset 20 cycles into a transaction, then a clean grant to requester 1
    mdl_lat = 80; mdl_data = 16'h1234;
    dev_a[2] = 7'h5A; reg_a[2] = 8'hC3; drive_addrs();
    serve_start("rst", 1'b0);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    chk("rst m_start", 32'(bus.m_start), 32'd0);
    chk("rst m_dev_addr", 32'(bus.m_dev_addr), 32'd0);
    chk("rst m_reg_addr", 32'(bus.m_reg_addr), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst bus_active", 32'(bus.bus_active), 32'd0);
    bus.req = 4'b0010;
    tick(); tick();
    rst = 1'b1; last_m = 3;
    mdl_lat = 15; mdl_data = 16'h7E57;
    serve_start("post_rst", 1'b0);
    serve_end("post_rst", 1'b1);
    repeat (G + 5) tick();

    chk("rsp overlap", 32'(overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
